scr1_tcm_portb_arb: RTL and testbench

// - Arbitrates port B (read/write, byte-enabled) of the dual-port TCM between two requesters:
//   M0 = core data LSU, M1 = external loader/debug (UART program loader on the Tang board).
// - Sequences single-beat accesses, routes the 1-cycle-latency read data back to the owner,
//   and supports bounded M1 burst lock for fast program download.
// - Port A (instruction fetch) is not touched.

---
 rtl/scr1_tcm_portb_arb_if.sv | 38 +++
 rtl/scr1_tcm_portb_arb.sv | 141 ++++++++++++++
 tb/tb_scr1_tcm_portb_arb.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_tcm_portb_arb_if.sv
// Requester-side and TCM-side port B bundles used by scr1_tcm_portb_arb.
// A requester drives the master modport of the request bundle; the arbiter drives the master modport of the memory bundle.

interface scr1_tcm_portb_arb_req_if #(
  parameter int W  = 32,
  parameter int AW = 14
) ();
  localparam int NB = W / 8;

  logic          req;
  logic          we;
  logic [NB-1:0] be;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic          ack;
  logic          rsp;
  logic [W-1:0]  rdata;

  modport master (output req, we, be, addr, wdata, input  ack, rsp, rdata);
  modport slave  (input  req, we, be, addr, wdata, output ack, rsp, rdata);
endinterface

interface scr1_tcm_portb_arb_mem_if #(
  parameter int W  = 32,
  parameter int AW = 14
) ();
  localparam int NB = W / 8;

  logic          renb;
  logic          wenb;
  logic [NB-1:0] webb;
  logic [AW-1:0] addrb;
  logic [W-1:0]  datab;
  logic [W-1:0]  qb;

  modport master (output renb, wenb, webb, addrb, datab, input  qb);
  modport slave  (input  renb, wenb, webb, addrb, datab, output qb);
endinterface

// File: rtl/scr1_tcm_portb_arb.sv
// TCM port B arbiter between the LSU (m0) and the loader/debug master (m1), with bounded m1 burst lock.
// Define SCR1_TCM_ARB_RR_EN for round-robin tie break; otherwise m0 wins ties (lock rule still applies).

module scr1_tcm_portb_arb #(
  parameter int          SCR1_WIDTH = 32,
  parameter logic [31:0] SCR1_SIZE  = 32'h0001_0000,
  parameter int          LOCK_MAX   = 16
) (
  input logic                      clk,
  input logic                      rst,
  scr1_tcm_portb_arb_req_if.slave  m0,
  scr1_tcm_portb_arb_req_if.slave  m1,
  input logic                      m1_lock,
  scr1_tcm_portb_arb_mem_if.master mem
);

  localparam int NB = SCR1_WIDTH / 8;
  localparam int AW = $clog2(SCR1_SIZE) - 2;
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  owner_e          last_grant_r;
  owner_e          rsp_owner_r;
  logic            rsp_valid_r;
  logic [CW-1:0]   lock_cnt_r;

  logic            lock_hold_s;
  logic            tie_m1_s;
  logic            grant_m0_s;
  logic            grant_m1_s;
  logic            rsp_m0_s;
  logic            rsp_m1_s;

  // Grant decision for the current cycle, resolved from requests and arbitration state.
  always_comb begin
    lock_hold_s = m1_lock & (last_grant_r == OWN_M1);
    tie_m1_s    = 1'b0;
    grant_m0_s  = 1'b0;
    grant_m1_s  = 1'b0;
    if (lock_hold_s) begin
      // The lock yields exactly one beat to m0 once the budget is spent.
      tie_m1_s = (lock_cnt_r != LOCK_MAX_C);
    end else begin
`ifdef SCR1_TCM_ARB_RR_EN
      tie_m1_s = (last_grant_r == OWN_M0);
`else
      tie_m1_s = 1'b0;
`endif
    end
    case ({m0.req, m1.req})
      2'b10: begin
        grant_m0_s = 1'b1;
        grant_m1_s = 1'b0;
      end
      2'b01: begin
        grant_m0_s = 1'b0;
        grant_m1_s = 1'b1;
      end
      2'b11: begin
        grant_m0_s = ~tie_m1_s;
        grant_m1_s = tie_m1_s;
      end
      default: begin
        grant_m0_s = 1'b0;
        grant_m1_s = 1'b0;
      end
    endcase
  end

  // Steer the granted master onto TCM port B; idle port is driven to zero.
  always_comb begin
    mem.renb  = 1'b0;
    mem.wenb  = 1'b0;
    mem.webb  = {NB{1'b0}};
    mem.addrb = {AW{1'b0}};
    mem.datab = {SCR1_WIDTH{1'b0}};
    if (grant_m0_s) begin
      mem.renb  = ~m0.we;
      mem.wenb  = m0.we;
      mem.webb  = m0.we ? m0.be : {NB{1'b0}};
      mem.addrb = m0.addr;
      mem.datab = m0.wdata;
    end else if (grant_m1_s) begin
      mem.renb  = ~m1.we;
      mem.wenb  = m1.we;
      mem.webb  = m1.we ? m1.be : {NB{1'b0}};
      mem.addrb = m1.addr;
      mem.datab = m1.wdata;
    end else begin
      mem.renb  = 1'b0;
      mem.wenb  = 1'b0;
      mem.webb  = {NB{1'b0}};
      mem.addrb = {AW{1'b0}};
      mem.datab = {SCR1_WIDTH{1'b0}};
    end
  end

  assign m0.ack   = grant_m0_s;
  assign m1.ack   = grant_m1_s;
  assign rsp_m0_s = rsp_valid_r & (rsp_owner_r == OWN_M0);
  assign rsp_m1_s = rsp_valid_r & (rsp_owner_r == OWN_M1);
  assign m0.rsp   = rsp_m0_s;
  assign m1.rsp   = rsp_m1_s;
  assign m0.rdata = rsp_m0_s ? mem.qb : {SCR1_WIDTH{1'b0}};
  assign m1.rdata = rsp_m1_s ? mem.qb : {SCR1_WIDTH{1'b0}};

  // Response pipe, last-grant history and lock budget counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= OWN_M1;
      rsp_owner_r  <= OWN_M0;
      rsp_valid_r  <= 1'b0;
      lock_cnt_r   <= {CW{1'b0}};
    end else begin
      rsp_valid_r <= grant_m0_s | grant_m1_s;
      if (grant_m0_s) begin
        last_grant_r <= OWN_M0;
        rsp_owner_r  <= OWN_M0;
      end else if (grant_m1_s) begin
        last_grant_r <= OWN_M1;
        rsp_owner_r  <= OWN_M1;
      end else begin
        last_grant_r <= last_grant_r;
        rsp_owner_r  <= rsp_owner_r;
      end
      if (grant_m0_s || !m1_lock) begin
        lock_cnt_r <= {CW{1'b0}};
      end else if (grant_m1_s && m0.req && (lock_cnt_r != LOCK_MAX_C)) begin
        lock_cnt_r <= lock_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        lock_cnt_r <= lock_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_scr1_tcm_portb_arb.sv
// Scoreboard bench for scr1_tcm_portb_arb (LOCK_MAX = 4); expected grant orders cover both tie-break builds.

module tb_scr1_tcm_portb_arb;

  localparam int W  = 32;
  localparam int AW = 14;
  localparam int NB = 4;

  typedef struct {
    bit            we;
    logic [NB-1:0] be;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
  } req_t;

  typedef struct {
    bit            own;
    bit            we;
    logic [NB-1:0] webb;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
  } gnt_t;

  typedef struct {
    bit            own;
    bit            rd;
    logic [W-1:0]  rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m1_lock = 1'b0;
  logic load = 1'b1;
  logic [W-1:0] tcm [256];

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  req_t m0_pend[$];
  req_t m1_pend[$];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scr1_tcm_portb_arb_req_if #(.W(W), .AW(AW)) m0_if ();
  scr1_tcm_portb_arb_req_if #(.W(W), .AW(AW)) m1_if ();
  scr1_tcm_portb_arb_mem_if #(.W(W), .AW(AW)) mem_if ();

  scr1_tcm_portb_arb #(
    .SCR1_WIDTH(32),
    .SCR1_SIZE (32'h0001_0000),
    .LOCK_MAX  (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m0     (m0_if),
    .m1     (m1_if),
    .m1_lock(m1_lock),
    .mem    (mem_if)
  );

  // TCM model: one-cycle read latency, byte-masked writes, preloaded at start.
  always @(posedge clk) begin
    if (load) begin
      tcm[8'h10] <= 32'h0140_2603;
      tcm[8'h20] <= 32'h1122_3344;
    end else begin
      if (mem_if.renb) mem_if.qb <= tcm[mem_if.addrb[7:0]];
      if (mem_if.wenb)
        for (int b = 0; b < NB; b++)
          if (mem_if.webb[b]) tcm[mem_if.addrb[7:0]][8*b +: 8] <= mem_if.datab[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input bit we, input logic [NB-1:0] be, input logic [AW-1:0] addr,
                              input logic [W-1:0] wdata, input logic [W-1:0] rdata);
    req_t r;
    r.we = we; r.be = be; r.addr = addr; r.wdata = wdata; r.rdata = rdata;
    return r;
  endfunction

  task automatic push_exp(input bit own, input req_t r, input bit with_rsp);
    gnt_t g;
    rsp_t e;
    g.own = own; g.we = r.we; g.webb = r.we ? r.be : 4'h0; g.addr = r.addr; g.wdata = r.wdata;
    gnt_q.push_back(g);
    e.own = own; e.rd = !r.we; e.rdata = r.rdata;
    if (with_rsp) rsp_q.push_back(e);
  endtask

  task automatic apply();
    if (m0_pend.size() > 0) begin
      m0_if.req = 1'b1; m0_if.we = m0_pend[0].we; m0_if.be = m0_pend[0].be;
      m0_if.addr = m0_pend[0].addr; m0_if.wdata = m0_pend[0].wdata;
    end else begin
      m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.be = 4'h0; m0_if.addr = 14'h0; m0_if.wdata = 32'h0;
    end
    if (m1_pend.size() > 0) begin
      m1_if.req = 1'b1; m1_if.we = m1_pend[0].we; m1_if.be = m1_pend[0].be;
      m1_if.addr = m1_pend[0].addr; m1_if.wdata = m1_pend[0].wdata;
    end else begin
      m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.be = 4'h0; m1_if.addr = 14'h0; m1_if.wdata = 32'h0;
    end
  endtask

  // bit i of seq is the expected winner of cycle i (1 = m1)
  task automatic run(input logic [31:0] seq, input int n);
    req_t r;
    for (int i = 0; i < n; i++) begin
      apply();
      if (seq[i]) begin
        r = m1_pend.pop_front();
        push_exp(1'b1, r, 1'b1);
      end else begin
        r = m0_pend.pop_front();
        push_exp(1'b0, r, 1'b1);
      end
      @(posedge clk); #1;
    end
    apply();
  endtask

  // Monitor: compare every grant and response against the scoreboard queues.
  initial begin
    gnt_t g;
    rsp_t e;
    forever begin
      @(negedge clk);
      check("single_ack", {63'h0, m0_if.ack & m1_if.ack}, 64'h0);
      if (m0_if.ack || m1_if.ack) begin
        if (gnt_q.size() == 0) begin
          check("spurious_grant", 64'h1, 64'h0);
        end else begin
          g = gnt_q.pop_front();
          check("gnt_owner", {63'h0, m1_if.ack}, {63'h0, g.own});
          check("gnt_renb",  {63'h0, mem_if.renb}, {63'h0, !g.we});
          check("gnt_wenb",  {63'h0, mem_if.wenb}, {63'h0, g.we});
          check("gnt_webb",  {60'h0, mem_if.webb}, {60'h0, g.webb});
          check("gnt_addrb", {50'h0, mem_if.addrb}, {50'h0, g.addr});
          check("gnt_datab", {32'h0, mem_if.datab}, {32'h0, g.wdata});
        end
      end else begin
        check("idle_mem", {12'h0, mem_if.renb, mem_if.wenb, mem_if.webb, mem_if.addrb, mem_if.datab}, 64'h0);
      end
      if (m0_if.rsp || m1_if.rsp) begin
        check("single_rsp", {63'h0, m0_if.rsp & m1_if.rsp}, 64'h0);
        if (rsp_q.size() == 0) begin
          check("spurious_rsp", 64'h1, 64'h0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_owner", {63'h0, m1_if.rsp}, {63'h0, e.own});
          if (e.rd)
            check("rsp_rdata", {32'h0, (e.own ? m1_if.rdata : m0_if.rdata)}, {32'h0, e.rdata});
        end
      end
      if (!m0_if.rsp) check("m0_rdata_zero", {32'h0, m0_if.rdata}, 64'h0);
      if (!m1_if.rsp) check("m1_rdata_zero", {32'h0, m1_if.rdata}, 64'h0);
    end
  end

  initial begin
    req_t r;
    apply();
    #2;
    check("reset_m0_rsp", {63'h0, m0_if.rsp}, 64'h0);
    check("reset_m1_rsp", {63'h0, m1_if.rsp}, 64'h0);
    check("reset_m0_rdata", {32'h0, m0_if.rdata}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    load = 1'b0;
    rst  = 1'b0;

    // single read, single partial write, readback
    m0_pend.push_back(mk(1'b0, 4'h0, 14'h010, 32'h0, 32'h0140_2603));
    run(32'h0, 1);
    m1_pend.push_back(mk(1'b1, 4'b0011, 14'h020, 32'hAABB_CCDD, 32'h0));
    run(32'h1, 1);
    m0_pend.push_back(mk(1'b0, 4'h0, 14'h020, 32'h0, 32'h1122_CCDD));
    run(32'h0, 1);
    m1_pend.push_back(mk(1'b1, 4'hF, 14'h030, 32'h5555_AAAA, 32'h0));
    run(32'h1, 1);

    // both requesting, no lock, last grant = m1
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) m0_pend.push_back(mk(1'b0, 4'h0, 14'h010, 32'h0, 32'h0140_2603));
      else            m0_pend.push_back(mk(1'b0, 4'h0, 14'h020, 32'h0, 32'h1122_CCDD));
      m1_pend.push_back(mk(1'b1, 4'hF, 14'h040 + 14'(i), 32'hC0DE_0000 + 32'(i), 32'h0));
    end
`ifdef SCR1_TCM_ARB_RR_EN
    run(32'h0000_0AAA, 12);
`else
    run(32'h0000_0FC0, 12);
`endif

    // m1 burst lock with m0 waiting, last grant = m1
    m1_lock = 1'b1;
    for (int i = 0; i < 2; i++) m0_pend.push_back(mk(1'b0, 4'h0, 14'h010, 32'h0, 32'h0140_2603));
    for (int i = 0; i < 8; i++) m1_pend.push_back(mk(1'b1, 4'(i + 1), 14'h060 + 14'(i), 32'h1234_0000 + 32'(i), 32'h0));
`ifdef SCR1_TCM_ARB_RR_EN
    run(32'h0000_01EF, 10);
`else
    run(32'h0000_03CF, 10);
`endif
    m1_lock = 1'b0;

    // read in flight when reset hits: its response must vanish
    r = mk(1'b0, 4'h0, 14'h010, 32'h0, 32'h0140_2603);
    m0_pend.push_back(r);
    apply();
    push_exp(1'b0, r, 1'b0);
    @(posedge clk); #1;
    void'(m0_pend.pop_front());
    apply();
    rst = 1'b1;
    #1;
    check("rst_kills_rsp", {63'h0, m0_if.rsp}, 64'h0);
    check("rst_kills_rdata", {32'h0, m0_if.rdata}, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m0_pend.push_back(mk(1'b0, 4'h0, 14'h020, 32'h0, 32'h1122_CCDD));
    m1_pend.push_back(mk(1'b1, 4'hF, 14'h050, 32'hFEED_BEEF, 32'h0));
    run(32'h0000_0002, 2);

    // idle stretch
    repeat (12) @(posedge clk);
    #1;
    check("gnt_queue_drained", 64'(gnt_q.size()), 64'h0);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
